// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised pipeline stage register with valid/ready flow control.
// Carries one DATA_W payload between two pipeline stages. With SKID=1 a second
// (skid) entry absorbs the beat that arrives while downstream stalls, so in_ready_o
// is decoded from state only and has no combinational path from out_ready_i.
// With SKID=0 a single entry is used and ready passes through combinationally.
// Empty entries read as zero (bubble = NOP). Also counts back-pressure cycles.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active high
//   flush_i      discard all held entries
//   in_valid_i   upstream payload valid
//   in_ready_o   stage can accept a payload this cycle
//   in_data_i    upstream payload
//   out_valid_o  stage holds a valid payload
//   out_ready_i  downstream accepts the payload this cycle
//   out_data_o   payload to downstream (main entry)
//   occupancy_o  number of entries held (0..2)
//   stall_cnt_o  saturating count of cycles with out_valid_o & !out_ready_i
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Encoding equals the entry count so occupancy is a direct read of the state.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic [CNT_W-1:0]  stall_q;

  logic in_fire;
  logic out_fire;
  logic stall_sat;

  assign out_valid_o = (state_q != S_EMPTY);
  assign out_data_o  = main_q;
  assign occupancy_o = 2'(state_q);
  assign stall_cnt_o = stall_q;

  // Ready: state-decoded with a skid entry, pass-through otherwise.
  generate
    if (SKID != 0) begin : g_ready_skid
      assign in_ready_o = (state_q != S_TWO);
    end else begin : g_ready_pass
      assign in_ready_o = !out_valid_o || out_ready_i;
    end
  endgenerate

  assign in_fire   = in_valid_i && in_ready_o;
  assign out_fire  = out_valid_o && out_ready_i;
  assign stall_sat = (stall_q == {CNT_W{1'b1}});

  // Entry state machine plus stall counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      // Flush squashes the entries but keeps the perf counter.
      if (out_valid_o && !out_ready_i && !flush_i && !stall_sat) begin
        stall_q <= stall_q + CNT_W'(1);
      end

      if (flush_i) begin
        state_q <= S_EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        case (state_q)
          S_EMPTY: begin
            if (in_fire) begin
              state_q <= S_ONE;
              main_q  <= in_data_i;
            end
          end
          S_ONE: begin
            if (in_fire && out_fire) begin
              main_q <= in_data_i;
            end else if (in_fire) begin
              // Downstream stalled: park the new beat behind the main entry.
              if (SKID != 0) begin
                state_q <= S_TWO;
                skid_q  <= in_data_i;
              end else begin
                main_q <= in_data_i;
              end
            end else if (out_fire) begin
              state_q <= S_EMPTY;
              main_q  <= '0;
            end
          end
          S_TWO: begin
            if (out_fire) begin
              state_q <= S_ONE;
              main_q  <= skid_q;
              skid_q  <= '0;
            end
          end
          default: begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
          end
        endcase
      end
    end
  end

endmodule
